// File: rtl/cozy_cfg_pkg.sv
// Shared types and constants for the connection-block configuration loader.
package cozy_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LOAD,
        CRC,
        COMMIT
    } cfg_state_e;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  CRC8_POLY = 8'h07;
    localparam int unsigned CRC_W     = 8;

    // Control bits per vertical CB: {ctrl3, ctrl1}
    function automatic int unsigned v_bits(input int unsigned cw);
        return 2 * (cw / 2);
    endfunction

    // Control bits per horizontal CB: {ctrl4, ctrl2, ctrl0}
    function automatic int unsigned h_bits(input int unsigned cw);
        return 3 * (cw / 2);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB-first, no reflection, zero init, no final XOR).
module crc8_serial
    import cozy_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb_c;

    assign fb_c = crc[7] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb_c ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/cb_config_loader.sv
// Serial, CRC-protected writer for the connection-block ctrl nibbles; commits atomically.
module cb_config_loader
    import cozy_cfg_pkg::*;
#(
    parameter  int unsigned CHANNEL_WIDTH = 8,
    parameter  int unsigned NUM_VCB       = 4,
    parameter  int unsigned NUM_HCB       = 4,
    localparam int unsigned V_BITS        = v_bits(CHANNEL_WIDTH),
    localparam int unsigned H_BITS        = h_bits(CHANNEL_WIDTH),
    localparam int unsigned V_TOT         = NUM_VCB * V_BITS,
    localparam int unsigned H_TOT         = NUM_HCB * H_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic [V_TOT-1:0] v_ctrl,
    output logic [H_TOT-1:0] h_ctrl,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_error
);

    localparam int unsigned PAYLOAD = V_TOT + H_TOT;
    localparam int unsigned CNT_W   = $clog2(PAYLOAD + 1);

    cfg_state_e         state_q, state_d;
    logic [7:0]         sync_q, sync_d;
    logic [PAYLOAD-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rx_crc_q, rx_crc_d;
    logic [V_TOT-1:0]   v_d;
    logic [H_TOT-1:0]   h_d;
    logic               done_d, err_d, ready_d, busy_d;

    logic               accept_c;
    logic               crc_en_c;
    logic               crc_clr_c;
    logic [7:0]         sync_shift_c;
    logic [7:0]         crc_calc;

    assign accept_c     = cfg_valid & cfg_ready;
    assign sync_shift_c = {sync_q[6:0], cfg_bit};
    assign crc_clr_c    = (state_q == IDLE);

    crc8_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr_c),
        .en    (crc_en_c),
        .din   (cfg_bit),
        .crc   (crc_calc)
    );

    // Next-state, datapath and status decode
    always_comb begin
        state_d  = state_q;
        sync_d   = sync_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        rx_crc_d = rx_crc_q;
        v_d      = v_ctrl;
        h_d      = h_ctrl;
        done_d   = cfg_done;
        err_d    = cfg_error;
        crc_en_c = 1'b0;

        if ((state_q != IDLE) && cfg_abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        sync_d  = 8'h00;
                        cnt_d   = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (accept_c) begin
                        sync_d = sync_shift_c;
                        if (sync_shift_c == SYNC_BYTE) begin
                            cnt_d   = '0;
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        shadow_d = {shadow_q[PAYLOAD-2:0], cfg_bit};
                        crc_en_c = 1'b1;
                        if (cnt_q == CNT_W'(PAYLOAD - 1)) begin
                            cnt_d   = '0;
                            state_d = CRC;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (accept_c) begin
                        rx_crc_d = {rx_crc_q[6:0], cfg_bit};
                        if (cnt_q == CNT_W'(CRC_W - 1)) begin
                            cnt_d   = '0;
                            state_d = COMMIT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (rx_crc_q == crc_calc) begin
                        v_d    = shadow_q[PAYLOAD-1 -: V_TOT];
                        h_d    = shadow_q[H_TOT-1:0];
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Handshake/status flags follow the next state so they are registered
        ready_d = (state_d == SYNC) || (state_d == LOAD) || (state_d == CRC);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= 8'h00;
            shadow_q  <= '0;
            cnt_q     <= '0;
            rx_crc_q  <= 8'h00;
            v_ctrl    <= '0;
            h_ctrl    <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            rx_crc_q  <= rx_crc_d;
            v_ctrl    <= v_d;
            h_ctrl    <= h_d;
            cfg_done  <= done_d;
            cfg_error <= err_d;
            cfg_ready <= ready_d;
            cfg_busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_cb_config_loader.sv
// Scoreboard bench for cb_config_loader: framed loads, CRC errors, noise/gaps, abort, reset.
module tb_cb_config_loader;

    localparam int unsigned VT = 32;
    localparam int unsigned HT = 48;
    localparam int unsigned PL = VT + HT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready;
    logic [VT-1:0] v_ctrl;
    logic [HT-1:0] h_ctrl;
    logic          cfg_busy, cfg_done, cfg_error;

    always #5 clk = ~clk;

    cb_config_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .v_ctrl    (v_ctrl),
        .h_ctrl    (h_ctrl),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    typedef struct {
        logic [VT-1:0] v;
        logic [HT-1:0] h;
        logic          done;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [VT-1:0] cur_v = '0;
    logic [HT-1:0] cur_h = '0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference CRC-8 computed bytewise over the payload as transmitted (MSB first)
    function automatic logic [7:0] crc8_ref(input logic [PL-1:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < int'(PL / 8); k++) begin
            c = c ^ p[PL-1-8*k -: 8];
            for (int j = 0; j < 8; j++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic send_bit(input logic b, input bit gaps);
        int g;
        int t;
        g = gaps ? int'($urandom_range(0, 3)) : 0;
        cfg_valid = 1'b0;
        repeat (g) begin
            @(posedge clk); #1;
        end
        cfg_valid = 1'b1;
        cfg_bit   = b;
        t = 0;
        while (!cfg_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cfg_ready) check("ready_timeout", 80'(cfg_ready), 80'(1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gaps);
    endtask

    task automatic do_start(input string tag);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        check({tag, "_start_busy"},  80'(cfg_busy),  80'(1));
        check({tag, "_start_ready"}, 80'(cfg_ready), 80'(1));
        check({tag, "_start_done"},  80'(cfg_done),  80'(0));
        check({tag, "_start_err"},   80'(cfg_error), 80'(0));
    endtask

    task automatic send_frame(input logic [VT-1:0] v, input logic [HT-1:0] h, input bit flip,
                              input bit junk, input bit gaps, input string tag);
        logic [PL-1:0] p;
        logic [7:0]    c;
        exp_t          e;
        p = {v, h};
        c = crc8_ref(p);
        if (flip) c[0] = ~c[0];
        e.v    = flip ? cur_v : v;
        e.h    = flip ? cur_h : h;
        e.done = !flip;
        e.err  = flip;
        sb.push_back(e);
        do_start(tag);
        if (junk) repeat (5) send_bit(1'b1, gaps);
        send_byte(8'hA5, gaps);
        for (int i = int'(PL) - 1; i >= 0; i--) send_bit(p[i], gaps);
        send_byte(c, gaps);
        // One edge after the last CRC bit: still in COMMIT, outputs not yet changed
        check({tag, "_pre_v"},     80'(v_ctrl),    80'(cur_v));
        check({tag, "_pre_busy"},  80'(cfg_busy),  80'(1));
        check({tag, "_pre_ready"}, 80'(cfg_ready), 80'(0));
        @(posedge clk); #1;
        e = sb.pop_front();
        check({tag, "_v"},    80'(v_ctrl),    80'(e.v));
        check({tag, "_h"},    80'(h_ctrl),    80'(e.h));
        check({tag, "_done"}, 80'(cfg_done),  80'(e.done));
        check({tag, "_err"},  80'(cfg_error), 80'(e.err));
        check({tag, "_busy"}, 80'(cfg_busy),  80'(0));
        if (!flip) begin
            cur_v = v;
            cur_h = h;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [VT-1:0] rv;
        logic [HT-1:0] rh;
        logic [PL-1:0] p;

        // Test 1: reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_v",     80'(v_ctrl),    80'(0));
        check("rst_h",     80'(h_ctrl),    80'(0));
        check("rst_ready", 80'(cfg_ready), 80'(0));
        check("rst_busy",  80'(cfg_busy),  80'(0));
        check("rst_done",  80'(cfg_done),  80'(0));
        check("rst_err",   80'(cfg_error), 80'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 2: good frame with VCB0 = {4'h3, 4'h5}
        send_frame(32'h0000_0035, 48'h0, 1'b0, 1'b0, 1'b0, "t2");
        check("t2_vcb0", 80'(v_ctrl[7:0]), 80'(8'h35));

        // Test 3: same frame, CRC bit0 flipped -> error, config held
        send_frame(32'h0000_0035, 48'h0, 1'b1, 1'b0, 1'b0, "t3");

        // Random good frame so the next load is observable
        rv = $urandom;
        rh = 48'({$urandom, $urandom});
        send_frame(rv, rh, 1'b0, 1'b0, 1'b0, "rnd");

        // Test 4: junk prefix plus random valid gaps
        send_frame(32'h0000_0035, 48'h0, 1'b0, 1'b1, 1'b1, "t4");

        // Test 5: abort during LOAD at bit 40
        rv = $urandom;
        rh = 48'({$urandom, $urandom});
        p  = {rv, rh};
        do_start("t5");
        send_byte(8'hA5, 1'b0);
        for (int i = int'(PL) - 1; i > int'(PL) - 41; i--) send_bit(p[i], 1'b0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check("t5_busy",  80'(cfg_busy),  80'(0));
        check("t5_ready", 80'(cfg_ready), 80'(0));
        check("t5_err",   80'(cfg_error), 80'(1));
        check("t5_done",  80'(cfg_done),  80'(0));
        check("t5_v",     80'(v_ctrl),    80'(cur_v));
        check("t5_h",     80'(h_ctrl),    80'(cur_h));
        // Abort in IDLE has no effect; start+abort together stays in IDLE
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        check("t5_idle_abort_err", 80'(cfg_error), 80'(1));
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        check("t5_both_busy", 80'(cfg_busy),  80'(0));
        check("t5_both_err",  80'(cfg_error), 80'(1));
        do_start("t5b");
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        check("t5b_abort_err",  80'(cfg_error), 80'(1));
        check("t5b_abort_busy", 80'(cfg_busy),  80'(0));

        // Test 6: async reset while receiving CRC bits
        do_start("t6");
        send_byte(8'hA5, 1'b0);
        for (int i = int'(PL) - 1; i >= 0; i--) send_bit(p[i], 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_v",     80'(v_ctrl),    80'(0));
        check("t6_h",     80'(h_ctrl),    80'(0));
        check("t6_busy",  80'(cfg_busy),  80'(0));
        check("t6_ready", 80'(cfg_ready), 80'(0));
        check("t6_done",  80'(cfg_done),  80'(0));
        check("t6_err",   80'(cfg_error), 80'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_v = '0;
        cur_h = '0;
        @(posedge clk); #1;
        send_frame(rv, rh, 1'b0, 1'b0, 1'b1, "t6_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
